lsu_ctrl: RTL

Load/store unit controller that sequences the single data-memory port on behalf of the pipeline. It accepts the memory operation presented to the MEM2 stage and runs one bus transaction on a req/gnt/rvalid port. It generates byte enables and lane-replicated write data, and reports completion to MEM2 via `lsu_req_done_o` / `lsu_rdata_o`. MEM2 stalls on `mem_oper != MEM_NOP && !lsu_req_done` and performs load sign/zero extension itself, so this block returns the raw bus word.

---
 rtl/lsu_ctrl_pkg.sv | 16 +
 rtl/lsu_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared memory-operation encoding used by the MEM2 stage and the LSU.
package lsu_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_oper_t;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: runs one req/gnt/rvalid bus transaction per
// MEM2 memory op, generates byte enables and lane-replicated store data,
// and returns the raw bus word on loads.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  mem_oper_t   mem_oper_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        kill_i,
    output logic        lsu_req_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        misaligned_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        op_valid;
    logic        misaligned;
    logic        idle_op;
    logic        issue;
    logic        mis_done;
    logic [1:0]  off;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // Decode the presented op into size/direction, lanes and issue conditions.
    always_comb begin
        off      = addr_i[1:0];
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_oper_i)
            MEM_LB, MEM_LBU: is_load = 1'b1;
            MEM_LH, MEM_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            MEM_LW:          begin is_load = 1'b1; is_word = 1'b1; end
            MEM_SB:          is_store = 1'b1;
            MEM_SH:          begin is_store = 1'b1; is_half = 1'b1; end
            MEM_SW:          begin is_store = 1'b1; is_word = 1'b1; end
            default:         ;
        endcase
        op_valid   = is_load | is_store;
        misaligned = MISALIGN_CHECK && ((is_half && off[0]) || (is_word && (off != 2'b00)));
        if (is_word) begin
            be_d    = 4'b1111;
            wdata_d = wdata_i;
        end else if (is_half) begin
            be_d    = 4'b0011 << {off[1], 1'b0};
            wdata_d = {2{wdata_i[15:0]}};
        end else begin
            be_d    = 4'b0001 << off;
            wdata_d = {4{wdata_i[7:0]}};
        end
        // rst_i gating keeps the combinational IDLE path quiet while in reset
        idle_op  = (state == IDLE) && !rst_i && !kill_i && op_valid;
        issue    = idle_op && !misaligned;
        mis_done = idle_op && misaligned;
    end

    // Transaction sequencer; request fields are captured on issue so REQ holds them stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        addr_q  <= {addr_i[31:2], 2'b00};
                        be_q    <= be_d;
                        we_q    <= is_store;
                        wdata_q <= wdata_d;
                        state   <= bus_gnt_i ? WAIT_RSP : REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and completion outputs: IDLE drives straight from the inputs, later states from captured fields.
    always_comb begin
        bus_req_o      = 1'b0;
        bus_addr_o     = addr_q;
        bus_be_o       = be_q;
        bus_we_o       = we_q;
        bus_wdata_o    = wdata_q;
        lsu_req_done_o = 1'b0;
        misaligned_o   = 1'b0;
        lsu_rdata_o    = '0;
        case (state)
            IDLE: begin
                bus_req_o      = issue;
                bus_addr_o     = {addr_i[31:2], 2'b00};
                bus_be_o       = be_d;
                bus_we_o       = is_store;
                bus_wdata_o    = wdata_d;
                lsu_req_done_o = mis_done;
                misaligned_o   = mis_done;
            end
            REQ: begin
                bus_req_o = 1'b1;
            end
            WAIT_RSP: begin
                lsu_req_done_o = bus_rvalid_i;
                lsu_rdata_o    = (bus_rvalid_i && !we_q) ? bus_rdata_i : '0;
            end
            default: ;
        endcase
    end

endmodule
